// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an 8-digit, active-low, common-anode hex display.
//
// Ports:
//   clk_i     system clock; all state updates on the rising edge
//   rst_i     synchronous active-high reset (overrides en_i and load_i)
//   data_i    32-bit value to display, one hex nibble per digit
//   load_i    single-cycle strobe capturing data_i
//   en_i      scan enable; low blanks the display and parks the scan at digit 0
//   dig_en_o  active-low digit enables, bit 0 = rightmost digit
//   seg_o     active-low segments {dp,g,f,e,d,c,b,a}; dp always off
//   frame_o   one-cycle pulse during the last cycle of a full 8-digit scan
//
// Parameter DIV: clock cycles each digit is displayed (2..2^20).
// Optional macro SEG7_ZERO_BLANK_EN: blanks leading zero digits (digit 0 always shown).
module seg7_scan #(
    parameter int unsigned DIV = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic        en_i,
    output logic [7:0]  dig_en_o,
    output logic [7:0]  seg_o,
    output logic        frame_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   act_q, act_d, shd_q, shd_d;
    logic          pend_q, pend_d;
    logic [7:0]    dig_q, dig_d, seg_q, seg_d;
    logic          frame_q, frame_d;
    logic          tick, wrap;
    logic [7:0]    seg_dec;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    assign tick = (cnt_q == CW'(DIV - 1));
    assign wrap = en_i & tick & (idx_q == 3'd7);

`ifdef SEG7_ZERO_BLANK_EN
    logic [2:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < 8; i++)
            if (act_q[4*i +: 4] != 4'h0) msd = 3'(i);
    end
    // Digits above the most significant nonzero nibble are dark; msd is never below 0 so digit 0 always shows.
    assign seg_dec = (idx_q > msd) ? 8'hFF : hex7(act_q[{idx_q, 2'b00} +: 4]);
`else
    assign seg_dec = hex7(act_q[{idx_q, 2'b00} +: 4]);
`endif

    always_comb begin
        cnt_d   = en_i ? (tick ? '0 : cnt_q + CW'(1)) : '0;
        idx_d   = en_i ? idx_q + {2'b00, tick} : 3'd0;
        dig_d   = en_i ? ~(8'h01 << idx_q) : 8'hFF;
        seg_d   = en_i ? seg_dec : 8'hFF;
        // Registered one cycle early so the pulse lines up with the cycle whose closing edge wraps 7->0;
        // a load presented during the pulse therefore lands directly in the active register.
        frame_d = en_i & (idx_q == 3'd7) & (cnt_q == CW'(DIV - 2));
        act_d   = act_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        if (!en_i) begin
            if (load_i) begin
                act_d  = data_i;
                shd_d  = data_i;
                pend_d = 1'b0;
            end
        end else if (wrap) begin
            // Frame boundary: the only point the active value may change while scanning.
            act_d  = load_i ? data_i : (pend_q ? shd_q : act_q);
            pend_d = 1'b0;
        end else if (load_i) begin
            shd_d  = data_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            act_q   <= '0;
            shd_q   <= '0;
            pend_q  <= 1'b0;
            dig_q   <= 8'hFF;
            seg_q   <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign dig_en_o = dig_q;
    assign seg_o    = seg_q;
    assign frame_o  = frame_q;
endmodule
